// File: rtl/mux_nway_arb.sv
// N-channel registered multiplexer with round-robin arbitration and valid/ready on every port.
// Optional build macro MUX_NWAY_ARB_FIXED_PRIO_EN selects lowest-index-wins priority instead.
module mux_nway_arb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(CHANNELS)-1:0]   out_sel,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0] w_chan [CHANNELS];
  logic             w_load;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant;

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign w_chan[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  assign w_load = !r_out_valid || out_ready;

`ifdef MUX_NWAY_ARB_FIXED_PRIO_EN
  // Lowest-index valid channel wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!w_grant_vld && in_valid[i]) begin
        w_grant_vld = 1'b1;
        w_grant     = SEL_W'(i);
      end
    end
  end
`else
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] r_ptr;

  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= CHANNELS) s = s - CHANNELS;
    return SEL_W'(s);
  endfunction

  // First valid channel at or after the pointer, wrapping at CHANNELS.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!w_grant_vld && in_valid[wrap_idx(r_ptr, k)]) begin
        w_grant_vld = 1'b1;
        w_grant     = wrap_idx(r_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_load && w_grant_vld) begin
      r_ptr <= (w_grant == LAST_CH) ? '0 : w_grant + SEL_W'(1);
    end
  end
`endif

  always_comb begin
    in_ready = '0;
    if (!reset && w_load && w_grant_vld) in_ready[w_grant] = 1'b1;
  end

  // Output register: load on grant, drain when consumed with nothing to replace it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load && w_grant_vld) begin
      r_out_data  <= w_chan[w_grant];
      r_out_sel   <= w_grant;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nway_arb.sv
// Bench for mux_nway_arb: directed scenarios plus randomized traffic against a queue-free
// behavioural model; a second 5-channel instance exercises the non-power-of-two wrap.
module tb_mux_nway_arb;

  localparam int unsigned W   = 16;
  localparam int unsigned N   = 8;
  localparam int unsigned N5  = 5;
  localparam int unsigned SW  = $clog2(N);
  localparam int unsigned SW5 = $clog2(N5);

  logic            clk;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            out_ready;

  logic            rst5;
  logic [N5*W-1:0] d5;
  logic [N5-1:0]   v5;
  logic [N5-1:0]   r5;
  logic [W-1:0]    od5;
  logic [SW5-1:0]  os5;
  logic            ov5;
  logic            ordy5;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] tbl [N] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
                            16'h5678, 16'h6789, 16'h789A, 16'h89AB};

  // Behavioural model state
  int           m_ptr;
  bit           m_ov;
  logic [W-1:0] m_od;
  int           m_os;

  mux_nway_arb #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nway_arb #(.WIDTH(W), .CHANNELS(N5)) dut5 (
    .clk(clk), .reset(rst5), .in_data(d5), .in_valid(v5), .in_ready(r5),
    .out_data(od5), .out_sel(os5), .out_valid(ov5), .out_ready(ordy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
`ifdef MUX_NWAY_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (m_ptr + k) % N;
`endif
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int exp_sw(input int k);
`ifdef MUX_NWAY_ARB_FIXED_PRIO_EN
    return 0 * k;
`else
    return k % N;
`endif
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    m_od  = '0;
    m_os  = 0;
  endtask

  // One clock of the 8-channel DUT against the model; returns the channels accepted.
  task automatic step(output logic [N-1:0] acc);
    int           g;
    bit           load;
    logic [W-1:0] cap;
    logic [N-1:0] er;
    #1;
    load = !m_ov || out_ready;
    g    = m_grant();
    er   = '0;
    cap  = '0;
    if (load && g >= 0) er[g] = 1'b1;
    if (g >= 0) cap = in_data[g*W +: W];
    check("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
    if (load && g >= 0) begin
      m_od  = cap;
      m_os  = g;
      m_ov  = 1'b1;
      m_ptr = (g + 1) % N;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_sel", 32'(out_sel), 32'(m_os));
    check("out_data", 32'(out_data), 32'(m_od));
    acc = er;
  endtask

  task automatic reset_check(input int cyc);
    rst = 1'b1;
    #1;
    model_reset();
    for (int c = 0; c <= cyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_sel", 32'(out_sel), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] acc;
    rst       = 1'b0;
    rst5      = 1'b0;
    out_ready = 1'b1;
    in_valid  = '1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = tbl[i];
    v5    = '0;
    d5    = '0;
    ordy5 = 1'b1;
    model_reset();
    #1;
    rst  = 1'b1;
    rst5 = 1'b1;
    @(posedge clk);
    #1;

    // Reset with every channel offering, then release
    reset_check(2);
    step(acc);
    check("rel_sel", 32'(out_sel), 32'd0);

    // Single channel
    in_valid = 8'h08;
    step(acc);
    check("single_data", 32'(out_data), 32'h4567);
    check("single_sel", 32'(out_sel), 32'd3);
    in_valid = '0;
    step(acc);
    check("single_drain", 32'(out_valid), 32'd0);

    // Sweep with a 3-cycle stall while channel 2's word is held
    reset_check(1);
    in_valid = '1;
    for (int k = 0; k < 3; k++) begin
      step(acc);
      check("sweep_sel", 32'(out_sel), 32'(exp_sw(k)));
      check("sweep_data", 32'(out_data), 32'(tbl[exp_sw(k)]));
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(acc);
      check("bp_sel", 32'(out_sel), 32'(exp_sw(2)));
      check("bp_data", 32'(out_data), 32'(tbl[exp_sw(2)]));
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    for (int k = 3; k < 14; k++) begin
      step(acc);
      check("sweep_valid", 32'(out_valid), 32'd1);
      check("sweep_sel", 32'(out_sel), 32'(exp_sw(k)));
      check("sweep_data", 32'(out_data), 32'(tbl[exp_sw(k)]));
    end

    // Asynchronous reset while channel 5's word is held
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sel", 32'(out_sel), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(acc);
    check("mid_rst_first", 32'(out_sel), 32'd0);

    // Randomized traffic; producers hold until accepted
    for (int n = 0; n < 400; n++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (!(in_valid[ch] && !acc[ch])) begin
          in_valid[ch] = ($urandom_range(0, 1) == 1);
          in_data[ch*W +: W] = 16'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end

    // Five-channel instance: pointer must wrap at 4
    for (int i = 0; i < N5; i++) d5[i*W +: W] = 16'hA000 + 16'(i);
    v5 = '1;
    @(posedge clk);
    #1;
    check("n5_rst_valid", 32'(ov5), 32'd0);
    rst5 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check("n5_valid", 32'(ov5), 32'd1);
`ifdef MUX_NWAY_ARB_FIXED_PRIO_EN
      check("n5_sel", 32'(os5), 32'd0);
`else
      check("n5_sel", 32'(os5), 32'(k % N5));
      check("n5_data", 32'(od5), 32'hA000 + 32'(k % N5));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
